// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin interval timer arbiter.
package timer_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_NREQ = 4;
   localparam int DEF_N    = 8;
   localparam int MAX_NREQ = 8;

   // First set request at or above ptr, wrapping modulo nreq; 0 when none is set.
   function automatic logic [2:0] rr_next(input logic [MAX_NREQ-1:0] req,
                                          input logic [2:0]          ptr,
                                          input int                  nreq);
      logic [2:0] pick;
      logic [2:0] cand;
      logic       found;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_NREQ; i++) begin
         cand = 3'((int'(ptr) + i) % nreq);
         if (!found && (i < nreq) && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/interval_counter.sv
// N-bit interval counter: synchronous clear beats enable, optional wrap at max.
module interval_counter
   import timer_arbiter_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         clear,
   input  logic         wrap,
   input  logic [N-1:0] max,
   output logic [N-1:0] count,
   output logic         at_max
);

   assign at_max = (count == max);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (at_max) begin
            if (wrap) count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NREQ timed requesters.
// Optional build macro TIMER_ARBITER_ABORT_EN: dropping req while granted aborts the interval.
module timer_arbiter
   import timer_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int N    = DEF_N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] duration,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [N-1:0]      count
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx_q, rr_ptr, pick, ptr_nxt;
   logic [N-1:0]    dur_q;
   logic            cnt_en, cnt_clr, at_max, abort;

   assign pick    = IW'(rr_next(MAX_NREQ'(req), 3'(rr_ptr), NREQ));
   assign ptr_nxt = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

`ifdef TIMER_ARBITER_ABORT_EN
   assign abort = ((state == LOAD) || (state == COUNT)) && !req[idx_q];
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|req) state_nxt = LOAD;
         LOAD:    state_nxt = abort ? IDLE : COUNT;
         COUNT:   if (abort)       state_nxt = IDLE;
                  else if (at_max) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The winner and its duration are captured once; later duration changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         dur_q  <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == IDLE && |req) begin
            idx_q <= pick;
            dur_q <= duration[int'(pick)*N +: N];
         end
         if (state == DONE || abort) rr_ptr <= ptr_nxt;
      end
   end

   always_comb begin
      gnt     = '0;
      done    = '0;
      busy    = (state != IDLE);
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      if (state != IDLE && !abort) gnt = NREQ'(1) << idx_q;
      unique case (state)
         LOAD:    cnt_clr = 1'b1;
         COUNT:   cnt_en  = !at_max && !abort;
         DONE:    done    = NREQ'(1) << idx_q;
         default: ;
      endcase
   end

   interval_counter #(.N(N)) u_counter (
      .clk    (clk),
      .rst    (rst),
      .enable (cnt_en),
      .clear  (cnt_clr),
      .wrap   (1'b0),
      .max    (dur_q),
      .count  (count),
      .at_max (at_max)
   );

endmodule
